// File: rtl/cross_bar_pkg.sv
// Shared crossbar parameters: master count and read-data type.
package cross_bar_pkg;
  localparam int unsigned MASTER_N = 4;
  typedef logic [31:0] data_t;
endpackage

// File: rtl/cross_bar_slave_resp_if.sv
// Bus bundle between the per-slave request mux, the slave port and the master return paths.
interface cross_bar_slave_resp_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned MasterN = cross_bar_pkg::MASTER_N;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);

  logic [MasterN-1:0]    grant;
  logic                  in_req;
  logic                  in_cmd;
  logic                  slave_req;
  logic                  slave_ack;
  logic                  slave_resp;
  cross_bar_pkg::data_t  slave_rdata;
  logic [MasterN-1:0]    master_ack;
  logic [MasterN-1:0]    master_resp;
  cross_bar_pkg::data_t  master_rdata [MasterN];
  logic [CntW-1:0]       pending;
  logic                  resp_err;

  modport slave (
    input  grant, in_req, in_cmd, slave_ack, slave_resp, slave_rdata,
    output slave_req, master_ack, master_resp, master_rdata, pending, resp_err
  );

  modport master (
    output grant, in_req, in_cmd, slave_ack, slave_resp, slave_rdata,
    input  slave_req, master_ack, master_resp, master_rdata, pending, resp_err
  );
endinterface

// File: rtl/cross_bar_slave_resp.sv
// Per-slave return path: gates requests on tracking capacity, routes acks to the granted master
// and steers in-order read responses back to the master that issued each read.
module cross_bar_slave_resp #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  cross_bar_slave_resp_if.slave          bus
);
  localparam int unsigned MasterN = cross_bar_pkg::MASTER_N;
  localparam int unsigned IdxW    = (MasterN > 1) ? $clog2(MasterN) : 1;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = $clog2(DEPTH + 1);

  logic [IdxW-1:0] fifo_q [DEPTH];
  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] count_q, count_d;
  logic            resp_err_q, resp_err_d;

  logic            full, empty, push, pop;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] head;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    // DEPTH need not be a power of two, so wrap explicitly.
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  assign bus.slave_req  = bus.in_req & ~full & ~reset;
  assign bus.master_ack = bus.grant & {MasterN{bus.slave_req & bus.slave_ack}};

  assign push = bus.slave_req & bus.slave_ack & ~bus.in_cmd;
  assign pop  = bus.slave_resp & ~empty;
  assign head = fifo_q[rp_q];

  // Grant is one-hot; an all-zero grant on a push is illegal and records index 0.
  always_comb begin
    grant_idx = '0;
    for (int i = MasterN - 1; i >= 0; i--) begin
      if (bus.grant[i]) grant_idx = IdxW'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < MasterN; i++) begin
      bus.master_resp[i]  = pop && (head == IdxW'(i));
      bus.master_rdata[i] = (pop && (head == IdxW'(i))) ? bus.slave_rdata : '0;
    end
  end

  always_comb begin
    wp_d       = push ? next_ptr(wp_q) : wp_q;
    rp_d       = pop ? next_ptr(rp_q) : rp_q;
    count_d    = count_q;
    resp_err_d = resp_err_q | (bus.slave_resp & empty);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      resp_err_q <= resp_err_d;
      if (push) fifo_q[wp_q] <= grant_idx;
    end
  end

  assign bus.pending  = count_q;
  assign bus.resp_err = resp_err_q;

endmodule

// File: tb/tb_cross_bar_slave_resp.sv
// Scoreboard bench for cross_bar_slave_resp: masters of acked reads are queued and checked
// against the routing of each slave response.
module tb_cross_bar_slave_resp;
  localparam int unsigned Depth   = 4;
  localparam int unsigned MasterN = cross_bar_pkg::MASTER_N;

  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  cross_bar_slave_resp_if #(.DEPTH(Depth)) bus ();

  cross_bar_slave_resp #(.DEPTH(Depth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle();
    bus.grant       = '0;
    bus.in_req      = 1'b0;
    bus.in_cmd      = 1'b0;
    bus.slave_ack   = 1'b0;
    bus.slave_resp  = 1'b0;
    bus.slave_rdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: optional request (read or write) from master m, optional slave response.
  task automatic cycle(input bit do_req, input bit is_write, input int m, input bit do_resp,
                       input logic [31:0] data, input bit exp_req, input int exp_pending);
    logic [MasterN-1:0] exp_ack, exp_resp;
    int owner;
    bus.grant       = do_req ? MasterN'(1 << m) : '0;
    bus.in_req      = do_req;
    bus.in_cmd      = is_write;
    bus.slave_ack   = do_req;
    bus.slave_resp  = do_resp;
    bus.slave_rdata = do_resp ? data : '0;
    @(negedge clk);
    total++;
    if (bus.slave_req !== exp_req)
      $display("FAIL slave_req: got %b want %b", bus.slave_req, exp_req);
    else passed++;
    exp_ack = (do_req && exp_req) ? MasterN'(1 << m) : '0;
    total++;
    if (bus.master_ack !== exp_ack)
      $display("FAIL master_ack: got %b want %b", bus.master_ack, exp_ack);
    else passed++;
    owner = -1;
    if (do_resp && exp_q.size() > 0) owner = exp_q.pop_front();
    if (do_req && exp_req && !is_write) exp_q.push_back(m);
    exp_resp = (owner >= 0) ? MasterN'(1 << owner) : '0;
    total++;
    if (bus.master_resp !== exp_resp)
      $display("FAIL master_resp: got %b want %b", bus.master_resp, exp_resp);
    else passed++;
    for (int j = 0; j < MasterN; j++) begin
      total++;
      if (bus.master_rdata[j] !== ((j == owner) ? data : 32'h0))
        $display("FAIL master_rdata[%0d]: got %h want %h", j, bus.master_rdata[j],
                 (j == owner) ? data : 32'h0);
      else passed++;
    end
    tick();
    total++;
    if (bus.pending !== 3'(exp_pending))
      $display("FAIL pending: got %0d want %0d", bus.pending, exp_pending);
    else passed++;
    idle();
  endtask

  task automatic check_err(input logic exp);
    total++;
    if (bus.resp_err !== exp) $display("FAIL resp_err: got %b want %b", bus.resp_err, exp);
    else passed++;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.in_req    = 1'b1;
    bus.grant     = 4'b0001;
    bus.slave_ack = 1'b1;
    @(negedge clk);
    total++;
    if (bus.slave_req !== 1'b0 || bus.master_ack !== '0)
      $display("FAIL req_in_reset: got req=%b ack=%b want 0/0", bus.slave_req, bus.master_ack);
    else passed++;
    tick();
    reset = 1'b0;
    idle();
    repeat (4) tick();
    cycle(0, 0, 0, 0, 0, 0, 0);
    check_err(1'b0);
  endtask

  task automatic test_write();
    cycle(1, 1, 2, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reads();
    cycle(1, 0, 2, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 2);
    cycle(1, 0, 3, 0, 0, 1, 3);
    cycle(0, 0, 0, 1, 32'hA1, 0, 2);
    cycle(0, 0, 0, 1, 32'hB2, 0, 1);
    cycle(0, 0, 0, 1, 32'hC3, 0, 0);
  endtask

  task automatic test_full();
    cycle(1, 0, 1, 0, 0, 1, 1);
    cycle(1, 0, 2, 0, 0, 1, 2);
    cycle(1, 0, 3, 0, 0, 1, 3);
    cycle(1, 0, 0, 0, 0, 1, 4);
    cycle(1, 0, 1, 0, 0, 0, 4);      // full: request blocked
    cycle(1, 0, 1, 1, 32'h11, 0, 3); // still full this cycle; pop frees a slot
    cycle(1, 0, 2, 1, 32'h22, 1, 3); // push + pop at DEPTH-1
    cycle(1, 0, 3, 0, 0, 1, 4);
    cycle(0, 0, 0, 1, 32'h33, 0, 3);
    cycle(0, 0, 0, 1, 32'h44, 0, 2);
    cycle(0, 0, 0, 1, 32'h55, 0, 1);
    cycle(0, 0, 0, 1, 32'h66, 0, 0);
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0, 0, 0, 1, 1);
    for (int k = 1; k < 12; k++) cycle(1, 0, (k * 3) % 4, 1, 32'h100 + k, 1, 1);
    cycle(0, 0, 0, 1, 32'h10C, 0, 0);
  endtask

  task automatic test_err();
    check_err(1'b0);
    cycle(0, 0, 0, 1, 32'h5A, 0, 0);
    check_err(1'b1);
    repeat (3) tick();
    check_err(1'b1);
    // Reset mid-operation discards outstanding reads.
    cycle(1, 0, 1, 0, 0, 1, 1);
    cycle(1, 0, 3, 0, 0, 1, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (bus.pending !== 3'd0) $display("FAIL pending_after_reset: got %0d want 0", bus.pending);
    else passed++;
    check_err(1'b0);
    cycle(0, 0, 0, 1, 32'h77, 0, 0);
    check_err(1'b1);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    test_reset();
    test_write();
    test_reads();
    test_full();
    test_back_to_back();
    test_err();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
